// File: rtl/bypass_drive.sv
// bypass_drive: producer side of the execute-stage bypass network.
// Buffers completed results from one FU lane in FIFO order, broadcasts the
// head entry on the bypass bus when granted, and writes the broadcast result
// to the physical register file one cycle later.
module bypass_drive #(
    parameter int SIZE_PHYSICAL_LOG = 7,
    parameter int SIZE_DATA         = 32,
    parameter int DEPTH             = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush_i,
    input  logic                          resultValid_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]  resultTag_i,
    input  logic [SIZE_DATA-1:0]          resultData_i,
    output logic                          resultReady_o,
    input  logic                          grant_i,
    output logic                          bypassValid_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]  bypassTag_o,
    output logic [SIZE_DATA-1:0]          bypassData_o,
    output logic                          rfWrEn_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]  rfWrAddr_o,
    output logic [SIZE_DATA-1:0]          rfWrData_o,
    output logic [$clog2(DEPTH):0]        occupancy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    // Result buffer storage
    logic [SIZE_PHYSICAL_LOG-1:0] tag_mem_q  [DEPTH];
    logic [SIZE_PHYSICAL_LOG-1:0] tag_mem_d  [DEPTH];
    logic [SIZE_DATA-1:0]         data_mem_q [DEPTH];
    logic [SIZE_DATA-1:0]         data_mem_d [DEPTH];

    // Buffer control state
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Broadcast and register-file stages
    logic                         bypassValid_q, bypassValid_d;
    logic [SIZE_PHYSICAL_LOG-1:0] bypassTag_q, bypassTag_d;
    logic [SIZE_DATA-1:0]         bypassData_q, bypassData_d;
    logic                         rfWrEn_q, rfWrEn_d;
    logic [SIZE_PHYSICAL_LOG-1:0] rfWrAddr_q, rfWrAddr_d;
    logic [SIZE_DATA-1:0]         rfWrData_q, rfWrData_d;

    logic ready_s;
    logic push_s;
    logic pop_s;

    // Ready depends only on the registered count, so a full buffer never
    // accepts a result even if it is being drained at the same edge.
    assign ready_s = (count_q < CNT_DEPTH);
    // Flush has priority: nothing is pushed or popped at a flush edge.
    assign push_s  = resultValid_i & ready_s & ~flush_i;
    assign pop_s   = grant_i & (count_q != CNT_ZERO) & ~flush_i;

    // Next-state for buffer storage: write the tail entry on push
    always_comb begin
        tag_mem_d  = tag_mem_q;
        data_mem_d = data_mem_q;
        if (push_s) begin
            tag_mem_d[tail_q]  = resultTag_i;
            data_mem_d[tail_q] = resultData_i;
        end else begin
            tag_mem_d  = tag_mem_q;
            data_mem_d = data_mem_q;
        end
    end

    // Next-state for pointers and entry count, with flush clearing the buffer
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = CNT_ZERO;
        end else begin
            if (push_s) begin
                tail_d = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Next-state for the broadcast triple and the trailing register-file write
    always_comb begin
        bypassValid_d = 1'b0;
        bypassTag_d   = bypassTag_q;
        bypassData_d  = bypassData_q;
        if (pop_s) begin
            bypassValid_d = 1'b1;
            bypassTag_d   = tag_mem_q[head_q];
            bypassData_d  = data_mem_q[head_q];
        end else begin
            bypassValid_d = 1'b0;
        end
        // Address/data always follow the broadcast registers; only the
        // enable is suppressed on flush.
        rfWrAddr_d = bypassTag_q;
        rfWrData_d = bypassData_q;
        if (flush_i) begin
            rfWrEn_d = 1'b0;
        end else begin
            rfWrEn_d = bypassValid_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_q[i]  <= {SIZE_PHYSICAL_LOG{1'b0}};
                data_mem_q[i] <= {SIZE_DATA{1'b0}};
            end
            head_q        <= {PTR_W{1'b0}};
            tail_q        <= {PTR_W{1'b0}};
            count_q       <= CNT_ZERO;
            bypassValid_q <= 1'b0;
            bypassTag_q   <= {SIZE_PHYSICAL_LOG{1'b0}};
            bypassData_q  <= {SIZE_DATA{1'b0}};
            rfWrEn_q      <= 1'b0;
            rfWrAddr_q    <= {SIZE_PHYSICAL_LOG{1'b0}};
            rfWrData_q    <= {SIZE_DATA{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_q[i]  <= tag_mem_d[i];
                data_mem_q[i] <= data_mem_d[i];
            end
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            bypassValid_q <= bypassValid_d;
            bypassTag_q   <= bypassTag_d;
            bypassData_q  <= bypassData_d;
            rfWrEn_q      <= rfWrEn_d;
            rfWrAddr_q    <= rfWrAddr_d;
            rfWrData_q    <= rfWrData_d;
        end
    end

    assign resultReady_o = ready_s;
    assign bypassValid_o = bypassValid_q;
    assign bypassTag_o   = bypassTag_q;
    assign bypassData_o  = bypassData_q;
    assign rfWrEn_o      = rfWrEn_q;
    assign rfWrAddr_o    = rfWrAddr_q;
    assign rfWrData_o    = rfWrData_q;
    assign occupancy_o   = count_q;

endmodule

// File: tb/tb_bypass_drive.sv
// Directed testbench for bypass_drive (default parameters, DEPTH = 2).
module tb_bypass_drive;

    logic        clk;
    logic        reset;
    logic        flush_i;
    logic        resultValid_i;
    logic [6:0]  resultTag_i;
    logic [31:0] resultData_i;
    logic        resultReady_o;
    logic        grant_i;
    logic        bypassValid_o;
    logic [6:0]  bypassTag_o;
    logic [31:0] bypassData_o;
    logic        rfWrEn_o;
    logic [6:0]  rfWrAddr_o;
    logic [31:0] rfWrData_o;
    logic [1:0]  occupancy_o;

    int checks;
    int errors;

    bypass_drive dut (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush_i),
        .resultValid_i (resultValid_i),
        .resultTag_i   (resultTag_i),
        .resultData_i  (resultData_i),
        .resultReady_o (resultReady_o),
        .grant_i       (grant_i),
        .bypassValid_o (bypassValid_o),
        .bypassTag_o   (bypassTag_o),
        .bypassData_o  (bypassData_o),
        .rfWrEn_o      (rfWrEn_o),
        .rfWrAddr_o    (rfWrAddr_o),
        .rfWrData_o    (rfWrData_o),
        .occupancy_o   (occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle before checking / driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] t, input logic [31:0] d, input logic g);
        resultValid_i = v;
        resultTag_i   = t;
        resultData_i  = d;
        grant_i       = g;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        flush_i = 1'b0;
        drive(1'b0, 7'h00, 32'h0, 1'b0);
        tick();
        tick();
        // Reset state
        chk("rst_valid", 64'(bypassValid_o), 64'd0);
        chk("rst_rfen",  64'(rfWrEn_o),      64'd0);
        chk("rst_occ",   64'(occupancy_o),   64'd0);
        chk("rst_ready", 64'(resultReady_o), 64'd1);
        chk("rst_tag",   64'(bypassTag_o),   64'd0);
        chk("rst_data",  64'(bypassData_o),  64'd0);
        reset = 1'b0;

        // Single result: push at edge 1, grant from cycle 1
        drive(1'b1, 7'h05, 32'hDEADBEEF, 1'b0);
        tick();
        chk("s_occ1",   64'(occupancy_o),   64'd1);
        chk("s_valid1", 64'(bypassValid_o), 64'd0);
        drive(1'b0, 7'h00, 32'h0, 1'b1);
        tick();
        chk("s_valid2", 64'(bypassValid_o), 64'd1);
        chk("s_tag2",   64'(bypassTag_o),   64'h05);
        chk("s_data2",  64'(bypassData_o),  64'hDEADBEEF);
        chk("s_rfen2",  64'(rfWrEn_o),      64'd0);
        chk("s_occ2",   64'(occupancy_o),   64'd0);
        tick();
        chk("s_valid3", 64'(bypassValid_o), 64'd0);
        chk("s_tag3",   64'(bypassTag_o),   64'h05);
        chk("s_rfen3",  64'(rfWrEn_o),      64'd1);
        chk("s_rfad3",  64'(rfWrAddr_o),    64'h05);
        chk("s_rfdt3",  64'(rfWrData_o),    64'hDEADBEEF);
        drive(1'b0, 7'h00, 32'h0, 1'b0);
        tick();
        chk("s_rfen4",  64'(rfWrEn_o),      64'd0);

        // Backpressure / full
        drive(1'b1, 7'h01, 32'h111, 1'b0);
        tick();
        drive(1'b1, 7'h02, 32'h222, 1'b0);
        tick();
        chk("f_occ2",   64'(occupancy_o),   64'd2);
        chk("f_ready0", 64'(resultReady_o), 64'd0);
        drive(1'b1, 7'h03, 32'h333, 1'b0);
        tick();
        chk("f_occ_rej", 64'(occupancy_o),  64'd2);
        drive(1'b0, 7'h00, 32'h0, 1'b1);
        tick();
        chk("f_v1",   64'(bypassValid_o), 64'd1);
        chk("f_t1",   64'(bypassTag_o),   64'h01);
        chk("f_d1",   64'(bypassData_o),  64'h111);
        chk("f_rdy1", 64'(resultReady_o), 64'd1);
        tick();
        chk("f_v2",   64'(bypassValid_o), 64'd1);
        chk("f_t2",   64'(bypassTag_o),   64'h02);
        chk("f_occ0", 64'(occupancy_o),   64'd0);
        tick();
        chk("f_v3",   64'(bypassValid_o), 64'd0);
        chk("f_t3h",  64'(bypassTag_o),   64'h02);
        drive(1'b1, 7'h03, 32'h333, 1'b0);
        tick();
        drive(1'b0, 7'h00, 32'h0, 1'b1);
        tick();
        chk("f_v4",   64'(bypassValid_o), 64'd1);
        chk("f_t4",   64'(bypassTag_o),   64'h03);
        chk("f_d4",   64'(bypassData_o),  64'h333);
        drive(1'b0, 7'h00, 32'h0, 1'b0);
        tick();
        chk("f_v5",   64'(bypassValid_o), 64'd0);

        // Streaming with simultaneous push/pop and pointer wrap
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 7'(8'h10 + i), 32'(32'hA000 + i), 1'b1);
            tick();
            chk("st_occ", 64'(occupancy_o), 64'd1);
            if (i == 0) begin
                chk("st_v0", 64'(bypassValid_o), 64'd0);
            end else begin
                chk("st_v",  64'(bypassValid_o), 64'd1);
                chk("st_t",  64'(bypassTag_o),   64'(8'h10 + i - 1));
                chk("st_d",  64'(bypassData_o),  64'(32'hA000 + i - 1));
            end
        end
        drive(1'b0, 7'h00, 32'h0, 1'b1);
        tick();
        chk("st_vlast", 64'(bypassValid_o), 64'd1);
        chk("st_tlast", 64'(bypassTag_o),   64'h15);
        chk("st_occ0",  64'(occupancy_o),   64'd0);
        drive(1'b0, 7'h00, 32'h0, 1'b0);
        tick();
        chk("st_vend",  64'(bypassValid_o), 64'd0);
        tick();

        // Flush with a concurrent push and grant
        drive(1'b1, 7'h20, 32'h2020, 1'b0);
        tick();
        drive(1'b1, 7'h21, 32'h2121, 1'b1);
        tick();
        chk("fl_v",   64'(bypassValid_o), 64'd1);
        chk("fl_t",   64'(bypassTag_o),   64'h20);
        chk("fl_occ", 64'(occupancy_o),   64'd1);
        flush_i = 1'b1;
        drive(1'b1, 7'h2F, 32'h2F2F, 1'b1);
        tick();
        chk("fl_v0",   64'(bypassValid_o), 64'd0);
        chk("fl_rf0",  64'(rfWrEn_o),      64'd0);
        chk("fl_occ0", 64'(occupancy_o),   64'd0);
        chk("fl_thold", 64'(bypassTag_o),  64'h20);
        flush_i = 1'b0;
        drive(1'b0, 7'h00, 32'h0, 1'b0);
        tick();
        chk("fl_drop", 64'(occupancy_o),   64'd0);
        drive(1'b1, 7'h30, 32'h3030, 1'b0);
        tick();
        drive(1'b0, 7'h00, 32'h0, 1'b1);
        tick();
        chk("fl_next_v", 64'(bypassValid_o), 64'd1);
        chk("fl_next_t", 64'(bypassTag_o),   64'h30);
        drive(1'b0, 7'h00, 32'h0, 1'b0);
        tick();
        chk("fl_rf_next", 64'(rfWrEn_o),   64'd1);
        chk("fl_rf_addr", 64'(rfWrAddr_o), 64'h30);
        tick();

        // Grant while empty
        drive(1'b0, 7'h00, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ge_v",   64'(bypassValid_o), 64'd0);
            chk("ge_rf",  64'(rfWrEn_o),      64'd0);
            chk("ge_t",   64'(bypassTag_o),   64'h30);
            chk("ge_occ", 64'(occupancy_o),   64'd0);
        end

        // Reset mid-operation
        drive(1'b1, 7'h40, 32'h4040, 1'b0);
        tick();
        drive(1'b1, 7'h41, 32'h4141, 1'b0);
        tick();
        drive(1'b0, 7'h00, 32'h0, 1'b1);
        tick();
        drive(1'b1, 7'h42, 32'h4242, 1'b1);
        tick();
        chk("rm_v",   64'(bypassValid_o), 64'd1);
        chk("rm_t",   64'(bypassTag_o),   64'h41);
        chk("rm_rf",  64'(rfWrEn_o),      64'd1);
        chk("rm_occ", 64'(occupancy_o),   64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rm_v0",   64'(bypassValid_o), 64'd0);
        chk("rm_rf0",  64'(rfWrEn_o),      64'd0);
        chk("rm_occ0", 64'(occupancy_o),   64'd0);
        chk("rm_rdy",  64'(resultReady_o), 64'd1);
        chk("rm_t0",   64'(bypassTag_o),   64'd0);
        drive(1'b0, 7'h00, 32'h0, 1'b0);
        tick();
        reset = 1'b0;
        drive(1'b1, 7'h50, 32'h5050, 1'b0);
        tick();
        drive(1'b0, 7'h00, 32'h0, 1'b1);
        tick();
        chk("rm_post_t", 64'(bypassTag_o), 64'h50);
        chk("rm_post_v", 64'(bypassValid_o), 64'd1);
        drive(1'b0, 7'h00, 32'h0, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
